i3c_table_mem: RTL and testbench
================================

// Module: i3c_table_mem
// PURPOSE
//  Parametrised, multi-requester table memory for the I3C controller (DAT, DCT and future tables).
//  Replaces a bare single-port RAM per table with one block that adds:
//   - round-robin arbitration of NumCh request channels onto one single-port array;
//   - a 1-cycle read pipeline with per-channel read-valid;
//   - hardware zeroisation after reset and on request.
//  Sits between the i3c core / CSR logic and the technology RAM.
// PARAMETERS
//  Width       64  data width in bits; must be a multiple of DataBitsPerMask
//  Depth       16  number of entries; need not be a power of two
//  DataBitsPerMask 32  bits per write-mask lane; NumLanes = Width/DataBitsPerMask
//  NumCh       2   number of requesting channels, 1..4
//  AddrW       $clog2(Depth) (derived, localparam); minimum 1
// PORTS
//  clk_i       in   1            clock
//  rst_ni      in   1            asynchronous active-low reset
//  req_i       in   NumCh        per-channel access request, held until granted
//  write_i     in   NumCh        1 = write, 0 = read
//  addr_i      in   NumCh*AddrW  per-channel entry address
//  wdata_i     in   NumCh*Width  per-channel write data
//  wmask_i     in   NumCh*NumLanes  per-channel lane write enables
//  gnt_o       out  NumCh        one-hot grant, same cycle as accepted request
//  rvalid_o    out  NumCh        one-hot read-data valid, 1 cycle after read grant
//  rdata_o     out  Width        read data, shared by all channels, qualified by rvalid_o
//  rerror_o    out  1            read error, qualified by any rvalid_o bit
//  init_req_i  in   1            pulse: zeroise the whole table
//  init_done_o out  1            1 = table usable; 0 while zeroising
// BEHAVIOUR
//  Reset values:
//   - gnt_o, rvalid_o, rerror_o, init_done_o = 0; rdata_o = 0.
//   - FSM enters INIT; round-robin pointer = channel 0.
//  FSM states: INIT, IDLE, DRAIN.
//   - INIT: write all-zero data (and zero parity) to address 0..Depth-1, one per cycle, Depth cycles.
//     No grants are issued. On the last address -> IDLE; init_done_o rises the following cycle.
//   - IDLE: arbiter active.
//     - If init_req_i=1 and no read is in flight: -> INIT.
//     - If init_req_i=1 and a read is in flight: -> DRAIN.
//     - Within the cycle init_req_i is seen, no new grant is issued.
//   - DRAIN: one cycle; the outstanding rvalid is delivered; -> INIT.
//  Arbitration:
//   - Combinational round-robin; at most one gnt_o bit per cycle.
//   - Priority starts at the channel after the last granted one; the pointer advances only on a grant.
//  Handshake:
//   - A transfer occurs when req_i[c] & gnt_o[c].
//   - The requester holds write_i, addr_i, wdata_i and wmask_i stable until granted.
//  Read:
//   - Array accessed in the grant cycle; rdata_o and rvalid_o[c] are valid exactly 1 cycle later.
//   - rdata_o holds its value until the next read completes.
//  Write:
//   - Only lanes with wmask_i=1 are updated.
//   - A read granted in the cycle after a write to the same address returns the new data.
//  Address range:
//   - addr_i >= Depth on a write: grant is issued and the write is dropped.
//   - addr_i >= Depth on a read: returns zero data with rerror_o=1.
//  Reset mid-operation:
//   - An asserted rst_ni aborts everything; the next release restarts INIT from address 0.
//   - Array contents are not relied on after reset.
//  NumCh=1: arbiter degenerates to gnt_o = req_i & init_done_o & ~init_req_i.
// CONFIGURATION
//  `I3C_TABLE_MEM_PARITY_EN`
//  With the macro defined:
//   - Array width becomes Width+NumLanes; one even-parity bit is stored per lane, written with that lane.
//   - On read, any lane parity mismatch sets rerror_o=1 with rvalid_o.
//   - INIT writes consistent parity.
//  Without the macro:
//   - No extra bits are stored.
//   - rerror_o reports only out-of-range reads.
// STRUCTURE
//  Shared package i3c_pkg holds:
//   - typedef table_mem_state_e {INIT, IDLE, DRAIN};
//   - the DAT/DCT instance constants: DatWidth=64, DctWidth=128, TableMaskBits=32.
//  Sub-module i3c_rr_arbiter (NumCh, req -> one-hot gnt, pointer update on grant).
//  The storage array is prim_ram_1p_adv, instanced inside this block.
// TESTING
//  1. Reset release, Depth=16: init_done_o=0 for 16 cycles, then 1; reading every address returns 0.
//  2. NumCh=2, both channels request continuously: grants alternate 0,1,0,1.
//     ch1 read of addr 3 previously written 64'hDEAD_BEEF_0123_4567 returns that value 1 cycle later
//     on rvalid_o=2'b10.
//  3. Write addr 5 data 64'hFFFF_FFFF_FFFF_FFFF with wmask 2'b01 over zeros, then read addr 5
//     next cycle: returns 64'h0000_0000_FFFF_FFFF.
//  4. Depth=12, read addr 13: rdata_o=0, rerror_o=1; write addr 13 is granted and no entry changes.
//  5. init_req_i in the same cycle as an outstanding read of addr 2: that rvalid is delivered,
//     no further grants, 16-cycle sweep, then all entries read 0.
//  6. With I3C_TABLE_MEM_PARITY_EN, flip one stored bit of addr 7 via backdoor:
//     the read of addr 7 gives rerror_o=1; the read of addr 8 gives rerror_o=0.

Source files
------------

// File: rtl/i3c_pkg.sv
// Shared I3C controller package.
// Holds the table-memory FSM state type and the DAT/DCT table instance constants.
package i3c_pkg;

  // Table memory controller states.
  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    DRAIN = 2'd2
  } table_mem_state_e;

  // DAT/DCT instance geometry.
  localparam int unsigned DatWidth      = 64;
  localparam int unsigned DctWidth      = 128;
  localparam int unsigned TableMaskBits = 32;

endpackage

// File: rtl/i3c_rr_arbiter.sv
// Round-robin arbiter for the table memory request channels.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : arbitration enable; no grant while low
//   req_i         : per-channel requests
//   gnt_o         : one-hot grant (combinational, same cycle as request)
//   idx_o         : index of the granted channel (valid when |gnt_o)
// Priority starts at the channel after the last granted one; the pointer
// only moves when a grant is issued.
module i3c_rr_arbiter #(
  parameter int unsigned NumCh = 2,
  localparam int unsigned IdxW = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [NumCh-1:0] req_i,
  output logic [NumCh-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand;
  logic            found;

  // Scan channels starting from the pointer; first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NumCh);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

  // Pointer moves to the channel after the one just granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= IdxW'((32'(idx_o) + 1) % NumCh);
    end
  end

endmodule

// File: rtl/prim_ram_1p_adv.sv
// Single-port synchronous RAM with bit write mask and range checking.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (read register only)
//   req_i/write_i : access strobe and direction
//   addr_i        : entry address; addresses >= Depth are out of range
//   wdata_i       : write data
//   wmask_i       : per-bit write enable
//   rdata_o       : registered read data, updated only by reads; zero when out of range
//   oob_o         : registered out-of-range flag for the last read
// Out-of-range writes are dropped. The array itself has no reset.
module prim_ram_1p_adv #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             write_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic [Width-1:0] rdata_o,
  output logic             oob_o
);

  logic [Width-1:0] mem [Depth];
  logic             in_range;

  assign in_range = 32'(addr_i) < Depth;

  // Masked write port.
  always_ff @(posedge clk_i) begin
    if (req_i && write_i && in_range) begin
      mem[addr_i] <= (mem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
    end
  end

  // Read register holds until the next read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
      oob_o   <= 1'b0;
    end else if (req_i && !write_i) begin
      rdata_o <= in_range ? mem[addr_i] : '0;
      oob_o   <= !in_range;
    end
  end

endmodule

// File: rtl/i3c_table_mem.sv
// Multi-requester table memory for the I3C controller (DAT, DCT, ...).
// Round-robin arbitrates NumCh channels onto one single-port array, returns
// read data one cycle after the grant, and zeroises the table after reset
// and on init_req_i.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   req_i, write_i  : per-channel request / direction (held until granted)
//   addr_i          : per-channel entry address, NumCh*AddrW
//   wdata_i         : per-channel write data, NumCh*Width
//   wmask_i         : per-channel lane write enables, NumCh*NumLanes
//   gnt_o           : one-hot grant, same cycle as the accepted request
//   rvalid_o        : one-hot read valid, one cycle after a read grant
//   rdata_o         : shared read data, holds until the next read completes
//   rerror_o        : read error, qualified by any rvalid_o bit
//   init_req_i      : pulse to zeroise the whole table
//   init_done_o     : table usable; low while zeroising
// Build option: define I3C_TABLE_MEM_PARITY_EN to store one even-parity bit
// per lane and flag lane parity mismatches on rerror_o.
module i3c_table_mem
  import i3c_pkg::*;
#(
  parameter int unsigned Width           = 64,
  parameter int unsigned Depth           = 16,
  parameter int unsigned DataBitsPerMask = 32,
  parameter int unsigned NumCh           = 2,
  localparam int unsigned AddrW          = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned NumLanes       = Width / DataBitsPerMask
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumCh-1:0]          req_i,
  input  logic [NumCh-1:0]          write_i,
  input  logic [NumCh*AddrW-1:0]    addr_i,
  input  logic [NumCh*Width-1:0]    wdata_i,
  input  logic [NumCh*NumLanes-1:0] wmask_i,
  output logic [NumCh-1:0]          gnt_o,
  output logic [NumCh-1:0]          rvalid_o,
  output logic [Width-1:0]          rdata_o,
  output logic                      rerror_o,
  input  logic                      init_req_i,
  output logic                      init_done_o
);

  localparam int unsigned IdxW = (NumCh > 1) ? $clog2(NumCh) : 1;
`ifdef I3C_TABLE_MEM_PARITY_EN
  localparam int unsigned RamW = Width + NumLanes;
`else
  localparam int unsigned RamW = Width;
`endif

  table_mem_state_e state_q, state_d;
  logic [AddrW-1:0] init_addr_q, init_addr_d;
  logic             arb_en;
  logic [IdxW-1:0]  gnt_idx;

  logic [AddrW-1:0]    sel_addr;
  logic [Width-1:0]    sel_wdata;
  logic [NumLanes-1:0] sel_wmask;
  logic                sel_write;

  logic             ram_req;
  logic             ram_write;
  logic [AddrW-1:0] ram_addr;
  logic [RamW-1:0]  ram_wdata;
  logic [RamW-1:0]  ram_bmask;
  logic [RamW-1:0]  ram_rdata;
  logic             ram_oob;
  logic             par_err;

  // Grants only in IDLE, and never in the cycle an init request is seen.
  assign arb_en = init_done_o & ~init_req_i;

  i3c_rr_arbiter #(
    .NumCh (NumCh)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (arb_en),
    .req_i  (req_i),
    .gnt_o  (gnt_o),
    .idx_o  (gnt_idx)
  );

  // Fields of the granted channel.
  assign sel_addr  = addr_i[32'(gnt_idx)*AddrW +: AddrW];
  assign sel_wdata = wdata_i[32'(gnt_idx)*Width +: Width];
  assign sel_wmask = wmask_i[32'(gnt_idx)*NumLanes +: NumLanes];
  assign sel_write = write_i[gnt_idx];

  // Next-state logic: zeroise sweep, idle arbitration, read drain.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    unique case (state_q)
      INIT: begin
        if (init_addr_q == AddrW'(Depth - 1)) begin
          state_d     = IDLE;
          init_addr_d = '0;
        end else begin
          init_addr_d = init_addr_q + AddrW'(1);
        end
      end
      IDLE: begin
        if (init_req_i) begin
          state_d = (|rvalid_o) ? DRAIN : INIT;
        end
      end
      DRAIN:   state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      init_done_o <= 1'b0;
      rvalid_o    <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_o <= (state_d == IDLE);
      rvalid_o    <= gnt_o & ~write_i;
    end
  end

  // Array port mux: the zeroise sweep owns the port in INIT.
  assign ram_req   = (state_q == INIT) | (|gnt_o);
  assign ram_write = (state_q == INIT) | sel_write;
  assign ram_addr  = (state_q == INIT) ? init_addr_q : sel_addr;

  // Expand lane enables to a bit mask; parity bits travel with their lane.
  always_comb begin
    ram_wdata = '0;
    ram_bmask = '0;
    for (int unsigned l = 0; l < NumLanes; l++) begin
      ram_wdata[l*DataBitsPerMask +: DataBitsPerMask] =
        sel_wdata[l*DataBitsPerMask +: DataBitsPerMask];
      ram_bmask[l*DataBitsPerMask +: DataBitsPerMask] = {DataBitsPerMask{sel_wmask[l]}};
`ifdef I3C_TABLE_MEM_PARITY_EN
      ram_wdata[Width+l] = ^sel_wdata[l*DataBitsPerMask +: DataBitsPerMask];
      ram_bmask[Width+l] = sel_wmask[l];
`endif
    end
    // All-zero data has zero even parity, so the sweep writes consistent entries.
    if (state_q == INIT) begin
      ram_wdata = '0;
      ram_bmask = '1;
    end
  end

  prim_ram_1p_adv #(
    .Width (RamW),
    .Depth (Depth)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (ram_req),
    .write_i (ram_write),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .wmask_i (ram_bmask),
    .rdata_o (ram_rdata),
    .oob_o   (ram_oob)
  );

`ifdef I3C_TABLE_MEM_PARITY_EN
  // Any lane whose data plus parity bit has odd weight is corrupt.
  always_comb begin
    par_err = 1'b0;
    for (int unsigned l = 0; l < NumLanes; l++) begin
      par_err = par_err |
        (^{ram_rdata[Width+l], ram_rdata[l*DataBitsPerMask +: DataBitsPerMask]});
    end
  end
`else
  assign par_err = 1'b0;
`endif

  assign rdata_o  = ram_rdata[Width-1:0];
  assign rerror_o = ram_oob | par_err;

endmodule

// File: tb/tb_i3c_table_mem.sv
// Self-checking bench for i3c_table_mem: vector table of single-channel
// transactions, read expectations queued at grant and checked on rvalid,
// plus sequences for round-robin, init/drain and out-of-range access.
module tb_i3c_table_mem;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req, wr, gnt, rvalid;
  logic [7:0]   addr;
  logic [127:0] wdata;
  logic [3:0]   wmask;
  logic [63:0]  rdata;
  logic         rerror, init_req, init_done;

  logic [1:0]   req12, wr12, gnt12, rvalid12;
  logic [7:0]   addr12;
  logic [127:0] wdata12;
  logic [3:0]   wmask12;
  logic [63:0]  rdata12;
  logic         rerror12, init_req12, init_done12;

  i3c_table_mem #(.Width(64), .Depth(16), .DataBitsPerMask(32), .NumCh(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .rerror_o(rerror), .init_req_i(init_req), .init_done_o(init_done)
  );

  i3c_table_mem #(.Width(64), .Depth(12), .DataBitsPerMask(32), .NumCh(2)) dut12 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req12), .write_i(wr12), .addr_i(addr12),
    .wdata_i(wdata12), .wmask_i(wmask12), .gnt_o(gnt12), .rvalid_o(rvalid12),
    .rdata_o(rdata12), .rerror_o(rerror12), .init_req_i(init_req12),
    .init_done_o(init_done12)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ch;
    logic [63:0] d;
    logic        e;
  } exp_t;

  typedef struct {
    logic        ch;
    logic        w;
    logic [3:0]  a;
    logic [63:0] wd;
    logic [1:0]  wm;
    logic [63:0] ed;
    logic        ee;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic last_ch = 1'b0;

  function automatic logic [1:0] onehot(input logic ch);
    onehot = ch ? 2'b10 : 2'b01;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endfunction

  // Scoreboard: every read granted in the previous cycle must show up now.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        if (rvalid !== onehot(mon_e.ch) || rdata !== mon_e.d || rerror !== mon_e.e) begin
          fails++;
          $display("FAIL rd_ch%0d: rvalid=%b rdata=%h rerror=%b, want rvalid=%b rdata=%h rerror=%b",
                   mon_e.ch, rvalid, rdata, rerror, onehot(mon_e.ch), mon_e.d, mon_e.e);
        end
      end else if (rvalid !== 2'b00) begin
        fails++;
        $display("FAIL spurious_rvalid: got %b, want 00", rvalid);
      end
    end
  end

  // One transaction on one channel; a read queues its expected result at grant.
  task automatic do_txn(input logic ch, input logic w, input logic [3:0] a,
                        input logic [63:0] wd, input logic [1:0] wm,
                        input logic [63:0] ed, input logic ee);
    bit granted;
    logic [1:0] g;
    granted = 1'b0;
    g = 2'b00;
    req[ch] = 1'b1;
    wr[ch] = w;
    addr[ch*4 +: 4] = a;
    wdata[ch*64 +: 64] = wd;
    wmask[ch*2 +: 2] = wm;
    for (int n = 0; n < 20 && !granted; n++) begin
      @(negedge clk);
      if (gnt[ch]) begin
        granted = 1'b1;
        g = gnt;
      end
      @(posedge clk);
      if (granted && !w) exp_q.push_back('{ch, ed, ee});
      #1;
    end
    req[ch] = 1'b0;
    if (granted) last_ch = ch;
    chk("gnt", 64'(g), 64'(onehot(ch)));
  endtask

  // Channel-0 transaction on the Depth=12 instance with direct read checks.
  task automatic txn12(input string nm, input logic w, input logic [3:0] a,
                       input logic [63:0] wd, input logic [63:0] ed, input logic ee);
    bit granted;
    granted = 1'b0;
    req12 = 2'b01;
    wr12 = {1'b0, w};
    addr12 = {4'd0, a};
    wdata12 = {64'd0, wd};
    wmask12 = 4'b0011;
    for (int n = 0; n < 20 && !granted; n++) begin
      @(negedge clk);
      if (gnt12 === 2'b01) granted = 1'b1;
      @(posedge clk);
      #1;
    end
    req12 = 2'b00;
    chk({nm, "_gnt"}, 64'(granted), 64'(1));
    if (!w) begin
      @(negedge clk);
      chk({nm, "_rvalid"}, 64'(rvalid12), 64'(2'b01));
      chk({nm, "_rdata"}, rdata12, ed);
      chk({nm, "_rerror"}, 64'(rerror12), 64'(ee));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lows;
    bit   done;
    bit   gnt_seen;
    logic exp_ch;

    req = 2'b11; wr = 2'b00; addr = '0; wdata = '0; wmask = '0; init_req = 1'b0;
    req12 = 2'b00; wr12 = 2'b00; addr12 = '0; wdata12 = '0; wmask12 = '0; init_req12 = 1'b0;

    // Reset values, with requests pending to prove no grant leaks out.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rerror", 64'(rerror), 64'(0));
    chk("rst_init_done", 64'(init_done), 64'(0));
    chk("rst_rdata", rdata, 64'h0);
    req = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Zeroise sweep length after reset release.
    lows = 0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (init_done) done = 1'b1;
      else lows++;
    end
    chk("init_low_cycles", 64'(lows), 64'(16));
    @(posedge clk);
    #1;

    // Vector table: read every entry, then masked writes and readbacks.
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'(i), 1'b0, 4'(i), 64'h0, 2'b00, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd3,  64'hDEAD_BEEF_0123_4567, 2'b11, 64'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd5,  64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd5,  64'h0, 2'b00, 64'h0000_0000_FFFF_FFFF, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd5,  64'h1234_5678_9ABC_DEF0, 2'b10, 64'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd5,  64'h0, 2'b00, 64'h1234_5678_FFFF_FFFF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd15, 64'h0, 2'b00, 64'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd3,  64'h0, 2'b00, 64'hDEAD_BEEF_0123_4567, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd0,  64'h0BAD_F00D_CAFE_0001, 2'b11, 64'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  64'h0, 2'b00, 64'h0BAD_F00D_CAFE_0001, 1'b0});
    for (int i = 0; i < vecs.size(); i++)
      do_txn(vecs[i].ch, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].wm, vecs[i].ed, vecs[i].ee);

    // Both channels requesting continuously: grants alternate.
    req = 2'b11;
    wr = 2'b00;
    addr = {4'd3, 4'd5};
    exp_ch = ~last_ch;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_gnt", 64'(gnt), 64'(onehot(exp_ch)));
      @(posedge clk);
      exp_q.push_back('{exp_ch, exp_ch ? 64'hDEAD_BEEF_0123_4567 : 64'h1234_5678_FFFF_FFFF, 1'b0});
      #1;
      last_ch = exp_ch;
      exp_ch = ~exp_ch;
    end
    req = 2'b00;

    // Init request while a read is outstanding: read delivered, no grants, sweep.
    do_txn(1'b0, 1'b1, 4'd2, 64'h5555_AAAA_5555_AAAA, 2'b11, 64'h0, 1'b0);
    req[1] = 1'b1;
    wr[1] = 1'b0;
    addr[7:4] = 4'd2;
    @(negedge clk);
    chk("drain_rd_gnt", 64'(gnt), 64'(2'b10));
    @(posedge clk);
    exp_q.push_back('{1'b1, 64'h5555_AAAA_5555_AAAA, 1'b0});
    #1;
    req = 2'b11;
    addr = {4'd4, 4'd4};
    init_req = 1'b1;
    @(negedge clk);
    chk("init_req_gnt", 64'(gnt), 64'(0));
    @(posedge clk);
    #1 init_req = 1'b0;
    lows = 0;
    done = 1'b0;
    gnt_seen = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (init_done) done = 1'b1;
      else begin
        lows++;
        if (gnt !== 2'b00) gnt_seen = 1'b1;
      end
    end
    req = 2'b00;
    chk("drain_sweep_low", 64'(lows), 64'(17));
    chk("sweep_no_gnt", 64'(gnt_seen), 64'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++)
      do_txn(vecs[i].ch, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].wm, vecs[i].ed, vecs[i].ee);

`ifdef I3C_TABLE_MEM_PARITY_EN
    // Corrupt one stored bit of entry 7; its neighbour stays clean.
    dut.u_ram.mem[7][3] = ~dut.u_ram.mem[7][3];
    do_txn(1'b0, 1'b0, 4'd7, 64'h0, 2'b00, 64'h8, 1'b1);
    do_txn(1'b1, 1'b0, 4'd8, 64'h0, 2'b00, 64'h0, 1'b0);
`endif

    // Depth=12 instance: out-of-range accesses and the last valid entry.
    txn12("wr11", 1'b1, 4'd11, 64'hCAFE_0000_1111_2222, 64'h0, 1'b0);
    txn12("wr13", 1'b1, 4'd13, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
    txn12("rd13", 1'b0, 4'd13, 64'h0, 64'h0, 1'b1);
    for (int i = 0; i < 11; i++)
      txn12("rd_lo", 1'b0, 4'(i), 64'h0, 64'h0, 1'b0);
    txn12("rd11", 1'b0, 4'd11, 64'h0, 64'hCAFE_0000_1111_2222, 1'b0);

    repeat (2) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
